// File: rtl/decimate_by_three.sv
// Decimate-by-3 FIR: 7-tap symmetric low-pass filter, one output per three accepted samples.
// Output register with valid/ready handshake; in_ready is combinational from the output state.
module decimate_by_three (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    phase_t             phase_q;
    phase_t             phase_d;
    logic signed [31:0] x_q [0:6];
    logic signed [31:0] x_d [0:6];
    logic signed [31:0] hist_new_s [0:6];
    logic signed [39:0] tap_s [0:6];
    logic signed [39:0] acc_s;
    logic signed [39:0] rnd_s;
    logic               out_valid_q;
    logic               out_valid_d;
    logic [31:0]        out_data_q;
    logic [31:0]        out_data_d;
    logic               accept_s;

    function automatic logic [31:0] sat32(input logic signed [39:0] v);
        logic [31:0] res;
        if (v > 40'sh007FFFFFFF) begin
            res = 32'h7FFFFFFF;
        end else if (v < 40'shFF80000000) begin
            res = 32'h80000000;
        end else begin
            res = v[31:0];
        end
        return res;
    endfunction

    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready && !clear;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Shifted history including the incoming sample, sign-extended for the accumulator.
    always_comb begin
        hist_new_s[0] = $signed(in_data);
        tap_s[0]      = $signed({{8{in_data[31]}}, in_data});
        for (int i = 1; i < 7; i++) begin
            hist_new_s[i] = x_q[i-1];
            tap_s[i]      = $signed({{8{x_q[i-1][31]}}, x_q[i-1]});
        end
    end

    // Filter with round-half-up; worst case |acc| < 2^38 so 40 bits cannot overflow.
    always_comb begin
        acc_s = (40'sd2  * tap_s[0]) - (40'sd6  * tap_s[1]) + (40'sd20 * tap_s[2])
              + (40'sd32 * tap_s[3]) + (40'sd20 * tap_s[4]) - (40'sd6  * tap_s[5])
              + (40'sd2  * tap_s[6]);
        rnd_s = (acc_s + 40'sd32) >>> 3'd6;
    end

    // Next-state logic: clear dominates, then accept/phase advance and output handshake.
    always_comb begin
        x_d         = x_q;
        phase_d     = phase_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clear) begin
            for (int i = 0; i < 7; i++) begin
                x_d[i] = 32'sd0;
            end
            phase_d     = PH0;
            out_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                x_d = hist_new_s;
                case (phase_q)
                    PH0:     phase_d = PH1;
                    PH1:     phase_d = PH2;
                    PH2:     phase_d = PH0;
                    default: phase_d = PH0;
                endcase
            end else begin
                phase_d = phase_q;
            end
            if (accept_s && (phase_q == PH2)) begin
                out_valid_d = 1'b1;
                out_data_d  = sat32(rnd_s);
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 7; i++) begin
                x_q[i] <= 32'sd0;
            end
            phase_q     <= PH0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else begin
            x_q         <= x_d;
            phase_q     <= phase_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_decimate_by_three.sv
// Self-checking bench for decimate_by_three: directed spec scenarios plus random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_decimate_by_three;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state: sample history, samples since last output, output register.
    longint hist [7];
    int     cnt;
    bit     m_valid;
    longint m_data;

    decimate_by_three dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint dout();
        return longint'($signed(out_data));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) hist[i] = 0;
        cnt     = 0;
        m_valid = 1'b0;
        m_data  = 0;
    endtask

    function automatic longint filt();
        longint acc;
        longint r;
        acc = 2*hist[0] - 6*hist[1] + 20*hist[2] + 32*hist[3]
            + 20*hist[4] - 6*hist[5] + 2*hist[6];
        r = (acc + 32) >>> 6;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check in_ready, update model at posedge, check outputs.
    task automatic step(input bit v, input logic [31:0] d, input bit rdy, input bit clr);
        bit acc_in;
        bit take;
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        #1;
        check_val("in_ready", longint'(in_ready), longint'(!m_valid || rdy));
        acc_in = v && (!m_valid || rdy) && !clr;
        take   = m_valid && rdy;
        @(posedge clock);
        if (clr) begin
            for (int i = 0; i < 7; i++) hist[i] = 0;
            cnt     = 0;
            m_valid = 1'b0;
        end else begin
            if (acc_in) begin
                for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = longint'($signed(d));
                cnt++;
            end
            if (acc_in && cnt == 3) begin
                cnt     = 0;
                m_valid = 1'b1;
                m_data  = filt();
            end else if (take) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_val("out_valid", longint'(out_valid), longint'(m_valid));
        if (m_valid) check_val("out_data", dout(), m_data);
    endtask

    localparam logic [31:0] MAXV = 32'h7FFFFFFF;
    localparam logic [31:0] MINV = 32'h80000000;

    initial begin
        longint      imp [4];
        logic [31:0] sat_seq [9];
        longint      held;
        imp     = '{20, -6, 0, 0};
        sat_seq = '{32'h0, 32'h0, MAXV, MINV, MAXV, MAXV, MAXV, MINV, MAXV};
        model_reset();

        // Reset state
        #12;
        check_val("rst_valid", longint'(out_valid), 0);
        check_val("rst_data", dout(), 0);
        check_val("rst_ready", longint'(in_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;

        // Impulse
        for (int k = 0; k < 12; k++) begin
            step(1'b1, (k == 0) ? 32'd64 : 32'd0, 1'b1, 1'b0);
            if (k % 3 == 2) check_val("impulse", dout(), imp[k/3]);
        end

        // DC
        step(1'b1, $urandom, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 32'd100, 1'b1, 1'b0);
            if (k == 8 || k == 11) check_val("dc", dout(), 100);
        end

        // Saturation high then low
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) step(1'b1, sat_seq[k], 1'b1, 1'b0);
        check_val("sat_hi", dout(), 64'sd2147483647);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(1'b1, (sat_seq[k] == MAXV) ? MINV : ((sat_seq[k] == MINV) ? MAXV : sat_seq[k]),
                 1'b1, 1'b0);
        end
        check_val("sat_lo", dout(), -64'sd2147483648);

        // Back-pressure
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(1000, 1), 1'b1, 1'b0);
        held = dout();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            check_val("bp_hold", dout(), held);
            check_val("bp_valid", longint'(out_valid), 1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_val("bp_release", longint'(out_valid), 0);
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(500, 0), 1'b1, 1'b0);

        // Clear
        for (int k = 0; k < 2; k++) step(1'b1, $urandom, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b1, 1'b1);
        step(1'b1, 32'd64, 1'b1, 1'b0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'd0, 1'b1, 1'b0);
        check_val("clear_imp", dout(), 20);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_val("clear_valid", longint'(out_valid), 0);

        // Asynchronous reset while output pending
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(9000, 1), 1'b0, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("arst_valid", longint'(out_valid), 0);
        check_val("arst_data", dout(), 0);
        check_val("arst_ready", longint'(in_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, $urandom_range(300, 1), 1'b1, 1'b0);
        check_val("arst_first", longint'(out_valid), 1);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            logic [31:0] d;
            d = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom_range(2000, 0) - 32'd1000);
            step($urandom_range(3, 0) != 0, d, $urandom_range(2, 0) != 0,
                 $urandom_range(40, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
